// File: rtl/ppa_pipe_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshakes on both sides.
// The prefix levels are spread over STAGES register boundaries, and the last boundary drives the outputs.
module ppa_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int LVLS = $clog2(WIDTH);

  // Carry-in is folded into bit 0's generate, so g[i] after the full tree is the carry into bit i+1.
  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] pg;
    logic [WIDTH-1:0] p0;
    logic             c0;
  } pre_t;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } res_t;

  function automatic pre_t init_pg(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                                   input logic cin_i, input logic sub_i);
    logic [WIDTH-1:0] b_eff;
    pre_t             x;
    b_eff  = sub_i ? ~b_i : b_i;
    x.c0   = sub_i | cin_i;
    x.p0   = a_i ^ b_eff;
    x.g    = a_i & b_eff;
    x.pg   = x.p0;
    x.g[0] = x.g[0] | (x.p0[0] & x.c0);
    return x;
  endfunction

  function automatic pre_t prefix_level(input pre_t x, input int lvl);
    pre_t nxt;
    nxt = x;
    for (int i = (1 << lvl); i < WIDTH; i++) begin
      nxt.g[i]  = x.g[i] | (x.pg[i] & x.g[i-(1<<lvl)]);
      nxt.pg[i] = x.pg[i] & x.pg[i-(1<<lvl)];
    end
    return nxt;
  endfunction

  function automatic pre_t prefix_span(input pre_t x, input int lo, input int hi);
    pre_t cur;
    cur = x;
    for (int l = 0; l < LVLS; l++) begin
      if (l >= lo && l < hi) cur = prefix_level(cur, l);
    end
    return cur;
  endfunction

  function automatic res_t finish_span(input pre_t x, input int lo);
    pre_t             cur;
    logic [WIDTH-1:0] carry;
    res_t             r;
    cur = x;
    for (int l = 0; l < LVLS; l++) begin
      if (l >= lo) cur = prefix_level(cur, l);
    end
    carry  = {cur.g[WIDTH-2:0], cur.c0};
    r.sum  = cur.p0 ^ carry;
    r.cout = cur.g[WIDTH-1];
    r.ovf  = cur.g[WIDTH-1] ^ cur.g[WIDTH-2];
    r.zero = ~|r.sum;
    return r;
  endfunction

  // First prefix level of segment k (between boundary k-1 and k): an even ceil-split of LVLS over STAGES-1.
  function automatic int seg_lo(input int k);
    return ((k - 1) * LVLS + (STAGES - 2)) / (STAGES - 1);
  endfunction

  logic              advance;
  logic [STAGES-1:0] vld_q, vld_d;
  res_t              res_q, res_d;

  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[STAGES-1];
  assign sum       = res_q.sum;
  assign cout      = res_q.cout;
  assign ovf       = res_q.ovf;
  assign zero      = res_q.zero;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    vld_d = vld_q;
    if (advance) begin
      vld_d[0] = in_valid;
      for (int k = 1; k < STAGES; k++) vld_d[k] = vld_q[k-1];
    end
  end

  generate
    if (STAGES == 1) begin : g_single
      always_comb begin
        res_d = res_q;
        if (advance) res_d = finish_span(init_pg(a, b, cin, sub), 0);
      end
    end else begin : g_multi
      pre_t pre_q [STAGES-1];
      pre_t pre_d [STAGES-1];

      always_comb begin
        for (int k = 0; k < STAGES - 1; k++) pre_d[k] = pre_q[k];
        res_d = res_q;
        if (advance) begin
          pre_d[0] = init_pg(a, b, cin, sub);
          for (int k = 1; k < STAGES - 1; k++)
            pre_d[k] = prefix_span(pre_q[k-1], seg_lo(k), seg_lo(k + 1));
          res_d = finish_span(pre_q[STAGES-2], seg_lo(STAGES - 1));
        end
      end

      // NOTE: internal datapath flops carry no reset; their contents are ignored until a valid bit follows them.
      always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES - 1; k++) pre_q[k] <= pre_d[k];
      end
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      res_q <= '0;
    end else begin
      vld_q <= vld_d;
      res_q <= res_d;
    end
  end

endmodule
